// File: rtl/core_pkg.sv
// Shared RV32I core definitions: opcode classes, hazard FSM states, register index width.
package core_pkg;

  localparam int REG_AW = 5;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2,
    REDIRECT = 2'd3
  } hz_state_e;

endpackage

// File: rtl/hz_src_decode.sv
// Source-register usage decode for an ID-stage instruction; purely combinational, zero latency.
// No handshake: outputs follow id_inst directly.
module hz_src_decode
  import core_pkg::*;
#(
  parameter int AW = REG_AW
) (
  input  logic [31:0]   id_inst,
  output logic          rs1_used,
  output logic          rs2_used,
  output logic [AW-1:0] rs1,
  output logic [AW-1:0] rs2
);

  logic [6:0] opcode;
  logic       unused_fields;

  assign opcode        = id_inst[6:0];
  assign rs1           = AW'(id_inst[19:15]);
  assign rs2           = AW'(id_inst[24:20]);
  assign unused_fields = ^{id_inst[31:25], id_inst[14:7]};

  always_comb begin
    rs1_used = 1'b0;
    rs2_used = 1'b0;
    unique case (opcode)
      OP_LOAD, OP_IMM, OP_JALR: rs1_used = 1'b1;
      OP_STORE, OP_BRANCH, OP_REG: begin
        rs1_used = 1'b1;
        rs2_used = 1'b1;
      end
      OP_LUI, OP_JAL: ;
      default: ;
    endcase
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Load-use / redirect / dmem-wait stall controller; control outputs are combinational from state and inputs.
// dmem_busy freezes the whole pipe and overrides every other event; counters saturate.
module hazard_ctrl
  import core_pkg::*;
#(
  parameter int REG_AW     = core_pkg::REG_AW,
  parameter int CNT_W      = 32,
  parameter int KILL_EXTRA = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [31:0]       id_inst,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_branch_taken,
  input  logic              dmem_busy,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic              idex_bubble,
  output logic              exmem_hold,
  output logic [1:0]        fsm_state,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam logic [3:0] KILL_INIT = 4'(KILL_EXTRA);

  hz_state_e         state, state_nxt, eff_state;
  logic [3:0]        kill_cnt, kill_nxt;
  logic              rs1_used, rs2_used, load_use;
  logic [REG_AW-1:0] rs1, rs2;

  hz_src_decode #(.AW(REG_AW)) u_src_decode (
    .id_inst  (id_inst),
    .rs1_used (rs1_used),
    .rs2_used (rs2_used),
    .rs1      (rs1),
    .rs2      (rs2)
  );

  assign load_use = id_valid & ex_mem_read & (ex_rd != '0) &
                    ((rs1_used & (rs1 == ex_rd)) | (rs2_used & (rs2 == ex_rd)));

  // A freeze entered from REDIRECT keeps kill_cnt, so a nonzero count means "resume REDIRECT".
  always_comb begin
    eff_state = state;
    if (state == MEM_WAIT) eff_state = (kill_cnt != 4'd0) ? REDIRECT : RUN;
  end

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    exmem_hold  = 1'b0;
    state_nxt   = RUN;
    kill_nxt    = kill_cnt;
    if (!rst_n) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      kill_nxt    = 4'd0;
    end else if (dmem_busy) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      exmem_hold = 1'b1;
      state_nxt  = MEM_WAIT;
    end else if (ex_branch_taken) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      if (KILL_EXTRA > 0) begin
        state_nxt = REDIRECT;
        kill_nxt  = KILL_INIT;
      end else begin
        kill_nxt  = 4'd0;
      end
    end else if (eff_state == REDIRECT) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      if (kill_cnt <= 4'd1) begin
        kill_nxt = 4'd0;
      end else begin
        kill_nxt  = kill_cnt - 4'd1;
        state_nxt = REDIRECT;
      end
    end else if (load_use && (eff_state != LU_STALL)) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
      state_nxt   = LU_STALL;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      kill_cnt  <= 4'd0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state    <= state_nxt;
      kill_cnt <= kill_nxt;
      if (!pc_write && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (ifid_flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  assign fsm_state = state;

endmodule
